// File: rtl/config_pkg.sv
// Shared constants for the config ramp controller: state encodings, per-state
// MU / Ca2+ targets and the SIE phase-duration table.
package config_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL      = 3'd0,
    ST_ANESTHESIA  = 3'd1,
    ST_PSYCHEDELIC = 3'd2,
    ST_FLOW        = 3'd3,
    ST_MEDITATION  = 3'd4
  } brain_state_e;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_RAMP = 1'b1
  } ramp_fsm_e;

  localparam int N_STATES   = 5;
  localparam int N_TBL_MU   = 6;
  localparam int N_SIE      = 6;
  localparam int SIE_W      = 16;
  localparam int MU_DEFAULT = 4;

  localparam int MU_TGT [N_STATES][N_TBL_MU] = '{
    '{4, 4, 4, 4, 4, 4},
    '{2, 6, 2, 2, 1, 1},
    '{4, 2, 4, 4, 6, 6},
    '{4, 2, 6, 6, 4, 4},
    '{4, 4, 2, 2, 2, 2}
  };

  localparam int CA_TGT [N_STATES] = '{8192, 12288, 4096, 8192, 6144};

  // Lanes: phase2..phase6, refractory (4 kHz cycles)
  localparam logic [SIE_W-1:0] SIE_TBL [N_STATES][N_SIE] = '{
    '{16'd14000, 16'd10000, 16'd10000, 16'd36000, 16'd16000, 16'd40000},
    '{16'd20000, 16'd8000,  16'd8000,  16'd24000, 16'd20000, 16'd60000},
    '{16'd16000, 16'd12000, 16'd16000, 16'd48000, 16'd20000, 16'd24000},
    '{16'd12000, 16'd8000,  16'd8000,  16'd32000, 16'd12000, 16'd48000},
    '{16'd16000, 16'd12000, 16'd12000, 16'd40000, 16'd20000, 16'd32000}
  };

  function automatic brain_state_e map_state(input logic [2:0] sel);
    if (sel > 3'd4) return ST_NORMAL;
    return brain_state_e'(sel);
  endfunction

  function automatic int mu_target(input brain_state_e st, input int lane);
    logic [2:0] l;
    l = lane[2:0];
    if (lane >= N_TBL_MU) return MU_DEFAULT;
    return MU_TGT[st][l];
  endfunction

  function automatic int ca_target(input brain_state_e st);
    return CA_TGT[st];
  endfunction

  function automatic logic [N_SIE*SIE_W-1:0] sie_word(input brain_state_e st);
    logic [N_SIE*SIE_W-1:0] w;
    w = '0;
    for (int i = 0; i < N_SIE; i++) begin
      w[i*SIE_W +: SIE_W] = SIE_TBL[st][i];
    end
    return w;
  endfunction

endpackage

// File: rtl/ramp_step_lane.sv
// One ramp channel: moves cur toward tgt by at most STEP, never overshooting.
module ramp_step_lane #(
  parameter int WIDTH = 18,
  parameter int STEP  = 1
) (
  input  logic signed [WIDTH-1:0] cur_i,
  input  logic signed [WIDTH-1:0] tgt_i,
  output logic signed [WIDTH-1:0] nxt_o
);

  localparam logic signed [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0]      STEP_N = WIDTH'(STEP);

  // One extra bit so the difference of two extreme values cannot wrap.
  logic signed [WIDTH:0] diff;
  assign diff = {tgt_i[WIDTH-1], tgt_i} - {cur_i[WIDTH-1], cur_i};

  always_comb begin
    nxt_o = tgt_i;
    if (diff > STEP_W) begin
      nxt_o = cur_i + STEP_N;
    end else if (diff < -STEP_W) begin
      nxt_o = cur_i - STEP_N;
    end
  end

endmodule

// File: rtl/config_ramp_controller.sv
// Commits a requested brain state and ramps MU lanes and the Ca2+ threshold
// toward its targets; SIE durations are staged until the sequencer is idle.
module config_ramp_controller
  import config_pkg::*;
#(
  parameter int WIDTH    = 18,
  parameter int FRAC     = 14,
  parameter int N_LAYERS = 6,
  parameter int MU_STEP  = 1,
  parameter int CA_STEP  = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic [2:0]                  state_select,
  input  logic                        sie_idle,
  output logic [N_LAYERS*WIDTH-1:0]   mu_dt,
  output logic signed [WIDTH-1:0]     ca_threshold,
  output logic [N_SIE*SIE_W-1:0]      sie_dur,
  output logic [2:0]                  active_state,
  output logic                        busy,
  output logic                        ramp_done,
  output logic                        sie_pending,
  output logic                        dbg_ramp
);

  typedef logic signed [WIDTH-1:0] val_t;

  val_t mu_q [N_LAYERS];
  val_t mu_d [N_LAYERS];
  val_t mu_tgt_q [N_LAYERS];
  val_t mu_tgt_d [N_LAYERS];
  val_t mu_nxt [N_LAYERS];
  val_t ca_q, ca_d, ca_tgt_q, ca_tgt_d, ca_nxt;

  brain_state_e             active_q, active_d, sel_mapped;
  ramp_fsm_e                state_q, state_d;
  logic                     ramp_done_q, ramp_done_d;
  logic [N_SIE*SIE_W-1:0]   sie_dur_q, sie_dur_d, sie_pend_q, sie_pend_d;
  logic                     sie_pending_q, sie_pending_d;
  logic                     commit, all_eq;

  for (genvar g = 0; g < N_LAYERS; g++) begin : g_mu
    ramp_step_lane #(.WIDTH(WIDTH), .STEP(MU_STEP)) u_lane (
      .cur_i (mu_q[g]),
      .tgt_i (mu_tgt_q[g]),
      .nxt_o (mu_nxt[g])
    );
    assign mu_dt[g*WIDTH +: WIDTH] = mu_q[g];
  end

  ramp_step_lane #(.WIDTH(WIDTH), .STEP(CA_STEP)) u_ca (
    .cur_i (ca_q),
    .tgt_i (ca_tgt_q),
    .nxt_o (ca_nxt)
  );

  assign sel_mapped = map_state(state_select);
  assign commit     = clk_en && (sel_mapped != active_q);

  always_comb begin
    all_eq = (ca_nxt == ca_tgt_q);
    for (int i = 0; i < N_LAYERS; i++) begin
      all_eq = all_eq && (mu_nxt[i] == mu_tgt_q[i]);
    end
  end

  // A commit only loads targets; values begin moving on the following strobe.
  always_comb begin
    mu_d          = mu_q;
    mu_tgt_d      = mu_tgt_q;
    ca_d          = ca_q;
    ca_tgt_d      = ca_tgt_q;
    active_d      = active_q;
    state_d       = state_q;
    ramp_done_d   = 1'b0;
    sie_dur_d     = sie_dur_q;
    sie_pend_d    = sie_pend_q;
    sie_pending_d = sie_pending_q;
    if (commit) begin
      active_d      = sel_mapped;
      state_d       = FSM_RAMP;
      ca_tgt_d      = WIDTH'(ca_target(sel_mapped));
      sie_pend_d    = sie_word(sel_mapped);
      sie_pending_d = 1'b1;
      for (int i = 0; i < N_LAYERS; i++) begin
        mu_tgt_d[i] = WIDTH'(mu_target(sel_mapped, i));
      end
    end else if (clk_en) begin
      if (state_q == FSM_RAMP) begin
        mu_d = mu_nxt;
        ca_d = ca_nxt;
        if (all_eq) begin
          state_d     = FSM_IDLE;
          ramp_done_d = 1'b1;
        end
      end
      if (sie_idle && sie_pending_q) begin
        sie_dur_d     = sie_pend_q;
        sie_pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_LAYERS; i++) begin
        mu_q[i]     <= WIDTH'(MU_DEFAULT);
        mu_tgt_q[i] <= WIDTH'(MU_DEFAULT);
      end
      ca_q          <= WIDTH'(ca_target(ST_NORMAL));
      ca_tgt_q      <= WIDTH'(ca_target(ST_NORMAL));
      active_q      <= ST_NORMAL;
      state_q       <= FSM_IDLE;
      ramp_done_q   <= 1'b0;
      sie_dur_q     <= sie_word(ST_NORMAL);
      sie_pend_q    <= sie_word(ST_NORMAL);
      sie_pending_q <= 1'b0;
    end else begin
      mu_q          <= mu_d;
      mu_tgt_q      <= mu_tgt_d;
      ca_q          <= ca_d;
      ca_tgt_q      <= ca_tgt_d;
      active_q      <= active_d;
      state_q       <= state_d;
      ramp_done_q   <= ramp_done_d;
      sie_dur_q     <= sie_dur_d;
      sie_pend_q    <= sie_pend_d;
      sie_pending_q <= sie_pending_d;
    end
  end

  assign ca_threshold = ca_q;
  assign sie_dur      = sie_dur_q;
  assign active_state = active_q;
  assign busy         = (state_q == FSM_RAMP);
  assign ramp_done    = ramp_done_q;
  assign sie_pending  = sie_pending_q;
  assign dbg_ramp     = (state_q == FSM_RAMP);

endmodule

// File: tb/tb_config_ramp_controller.sv
// Directed bench for config_ramp_controller with hand-computed expectations.
module tb_config_ramp_controller;

  localparam int W  = 18;
  localparam int NL = 6;

  logic            clk;
  logic            rst;
  logic            clk_en;
  logic [2:0]      state_select;
  logic            sie_idle;
  logic [NL*W-1:0] mu_dt;
  logic signed [W-1:0] ca_threshold;
  logic [95:0]     sie_dur;
  logic [2:0]      active_state;
  logic            busy;
  logic            ramp_done;
  logic            sie_pending;
  logic            dbg_ramp;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  config_ramp_controller dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .state_select (state_select),
    .sie_idle     (sie_idle),
    .mu_dt        (mu_dt),
    .ca_threshold (ca_threshold),
    .sie_dur      (sie_dur),
    .active_state (active_state),
    .busy         (busy),
    .ramp_done    (ramp_done),
    .sie_pending  (sie_pending),
    .dbg_ramp     (dbg_ramp)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [31:0] mu_lane(input int i);
    logic signed [W-1:0] v;
    v = mu_dt[i*W +: W];
    return v;
  endfunction

  function automatic logic signed [31:0] ca_val();
    return ca_threshold;
  endfunction

  function automatic logic [31:0] sie_lane(input int i);
    return {16'd0, sie_dur[i*16 +: 16]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < NL; i++) check_eq({tag, "_mu"}, mu_lane(i), 4);
    check_eq({tag, "_ca"}, ca_val(), 8192);
    check_eq({tag, "_active"}, {29'd0, active_state}, 0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 0);
    check_eq({tag, "_done"}, {31'd0, ramp_done}, 0);
    check_eq({tag, "_pending"}, {31'd0, sie_pending}, 0);
    check_eq({tag, "_fsm"}, {31'd0, dbg_ramp}, 0);
    check_eq({tag, "_sie0"}, sie_lane(0), 14000);
    check_eq({tag, "_sie3"}, sie_lane(3), 36000);
    check_eq({tag, "_sie5"}, sie_lane(5), 40000);
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; state_select = 3'd0; sie_idle = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_values("reset");

    // NORMAL -> ANESTHESIA with sie_idle low
    clk_en = 1'b1; state_select = 3'd1;
    tick();
    check_eq("commit_active", {29'd0, active_state}, 1);
    check_eq("commit_busy", {31'd0, busy}, 1);
    check_eq("commit_ca_hold", ca_val(), 8192);
    check_eq("commit_mu4_hold", mu_lane(4), 4);
    check_eq("commit_pending", {31'd0, sie_pending}, 1);
    check_eq("commit_sie_hold", sie_lane(0), 14000);
    done_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      done_cnt += int'(ramp_done);
      if (k == 1) check_eq("an_ca_s1", ca_val(), 8448);
      if (k == 2) check_eq("an_l6_s2", mu_lane(1), 6);
      if (k == 2) check_eq("an_theta_s2", mu_lane(0), 2);
      if (k == 3) check_eq("an_l4_s3", mu_lane(4), 1);
      if (k == 15) check_eq("an_ca_s15", ca_val(), 12032);
      if (k == 15) check_eq("an_busy_s15", {31'd0, busy}, 1);
    end
    check_eq("an_ca_final", ca_val(), 12288);
    check_eq("an_done_s16", {31'd0, ramp_done}, 1);
    check_eq("an_busy_s16", {31'd0, busy}, 0);
    check_eq("an_l23_final", mu_lane(5), 1);
    check_eq("an_sie_still_old", sie_lane(5), 40000);
    sie_idle = 1'b1;
    tick();
    check_eq("an_done_single", {31'd0, ramp_done}, 0);
    check_eq("an_done_count", done_cnt, 1);
    check_eq("an_sie0", sie_lane(0), 20000);
    check_eq("an_sie5", sie_lane(5), 60000);
    check_eq("an_pending_clr", {31'd0, sie_pending}, 0);

    // ANESTHESIA interrupted at step 5 by PSYCHEDELIC
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_eq("int_commit_active", {29'd0, active_state}, 1);
    done_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      done_cnt += int'(ramp_done);
    end
    check_eq("int_ca_s5", ca_val(), 9472);
    state_select = 3'd2;
    tick();
    check_eq("int_retarget_ca", ca_val(), 9472);
    check_eq("int_retarget_active", {29'd0, active_state}, 2);
    for (int k = 1; k <= 21; k++) begin
      tick();
      done_cnt += int'(ramp_done);
      if (k == 20) check_eq("int_ca_s20", ca_val(), 4352);
      if (k == 20) check_eq("int_busy_s20", {31'd0, busy}, 1);
    end
    check_eq("int_ca_final", ca_val(), 4096);
    check_eq("int_done_s21", {31'd0, ramp_done}, 1);
    check_eq("int_l4", mu_lane(4), 6);
    check_eq("int_l6", mu_lane(1), 2);
    check_eq("int_theta", mu_lane(0), 4);
    check_eq("int_done_count", done_cnt, 1);
    check_eq("int_sie3", sie_lane(3), 48000);

    // MEDITATION commit with sie_idle low, then a 50-cycle freeze mid-ramp
    sie_idle = 1'b0; state_select = 3'd4;
    tick();
    check_eq("med_active", {29'd0, active_state}, 4);
    check_eq("med_pending", {31'd0, sie_pending}, 1);
    check_eq("med_sie_hold", sie_lane(3), 48000);
    repeat (3) tick();
    check_eq("med_ca_s3", ca_val(), 4864);
    clk_en = 1'b0; sie_idle = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      done_cnt += int'(ramp_done);
    end
    check_eq("frz_done", done_cnt, 0);
    check_eq("frz_ca", ca_val(), 4864);
    check_eq("frz_l4", mu_lane(4), 3);
    check_eq("frz_busy", {31'd0, busy}, 1);
    check_eq("frz_pending", {31'd0, sie_pending}, 1);
    check_eq("frz_sie", sie_lane(3), 48000);
    clk_en = 1'b1;
    tick();
    check_eq("res_ca_s4", ca_val(), 5120);
    check_eq("res_l4_s4", mu_lane(4), 2);
    check_eq("res_sie2", sie_lane(2), 12000);
    check_eq("res_sie3", sie_lane(3), 40000);
    check_eq("res_sie5", sie_lane(5), 32000);
    check_eq("res_pending", {31'd0, sie_pending}, 0);
    repeat (4) tick();
    check_eq("med_ca_final", ca_val(), 6144);
    check_eq("med_done", {31'd0, ramp_done}, 1);
    check_eq("med_busy", {31'd0, busy}, 0);
    check_eq("med_l6", mu_lane(1), 4);

    // FLOW, then out-of-range select maps to NORMAL
    state_select = 3'd3;
    tick();
    check_eq("flow_active", {29'd0, active_state}, 3);
    repeat (10) tick();
    check_eq("flow_l5b", mu_lane(2), 6);
    check_eq("flow_l6", mu_lane(1), 2);
    check_eq("flow_ca", ca_val(), 8192);
    check_eq("flow_busy", {31'd0, busy}, 0);
    state_select = 3'd7;
    tick();
    check_eq("sel7_active", {29'd0, active_state}, 0);
    check_eq("sel7_busy", {31'd0, busy}, 1);
    repeat (10) tick();
    check_eq("sel7_l5b", mu_lane(2), 4);
    check_eq("sel7_l6", mu_lane(1), 4);
    check_eq("sel7_ca", ca_val(), 8192);
    check_eq("sel7_busy_end", {31'd0, busy}, 0);
    state_select = 3'd5;
    tick();
    check_eq("sel5_no_commit", {31'd0, busy}, 0);
    check_eq("sel5_active", {29'd0, active_state}, 0);

    // Commit whose targets already equal the outputs
    state_select = 3'd2;
    tick();
    state_select = 3'd0;
    tick();
    check_eq("eq_busy", {31'd0, busy}, 1);
    check_eq("eq_done_early", {31'd0, ramp_done}, 0);
    check_eq("eq_ca", ca_val(), 8192);
    tick();
    check_eq("eq_done", {31'd0, ramp_done}, 1);
    check_eq("eq_busy_end", {31'd0, busy}, 0);
    tick();
    check_eq("eq_done_clr", {31'd0, ramp_done}, 0);

    // Reset mid-ramp with clk_en high
    state_select = 3'd1;
    tick();
    repeat (4) tick();
    check_eq("pre_rst_ca", ca_val(), 9216);
    check_eq("pre_rst_sie", sie_lane(0), 20000);
    rst = 1'b1;
    tick();
    check_reset_values("midrst");
    rst = 1'b0; state_select = 3'd0;
    tick();
    check_eq("post_rst_busy", {31'd0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
